// File: rtl/instr_prefetch.sv
// Instruction prefetch stage: issues sequential word fetches, buffers in-order responses in a
// FIFO and hands them to the core with their PC; redirects flush the buffer and drain stale responses.
module instr_prefetch #(
  parameter int unsigned DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  output logic        mem_req_valid,
  input  logic        mem_req_ready,
  output logic [31:0] mem_req_addr,
  input  logic        mem_rsp_valid,
  input  logic [31:0] mem_rsp_data,
  output logic        instr_valid,
  input  logic        instr_ready,
  output logic [31:0] instr,
  output logic [31:0] instr_pc,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic [1:0]  dbg_state
);
  // Handshakes: a transfer happens on a rising edge where valid && ready are both 1. valid never
  // depends on ready; mem_rsp_valid has no ready and must always be absorbed.

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;
  localparam logic [CW:0] DEPTH_W = (CW + 1)'(DEPTH);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_t;

  state_t        state;
  logic [31:0]   fetch_addr;
  logic [31:0]   head_pc;
  logic [CW-1:0] count;
  logic [CW-1:0] inflight;
  logic [CW-1:0] discard;
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [31:0]   fifo_mem [DEPTH];

  logic [CW:0]   occupancy;
  logic          accept;
  logic          push;
  logic          pop;
  logic          rsp_drop;
  logic [CW-1:0] discard_next;
  logic [31:0]   redirect_target;

  // Buffered plus in-flight words never exceed DEPTH, so a response always has a free slot.
  assign occupancy     = {1'b0, count} + {1'b0, inflight};
  assign mem_req_valid = (state == RUN) && !redirect_valid && (occupancy < DEPTH_W);
  assign mem_req_addr  = fetch_addr;
  assign instr_valid   = (count != '0);
  assign instr         = fifo_mem[rd_ptr];
  assign instr_pc      = head_pc;
  assign dbg_state     = state;

  assign accept          = mem_req_valid && mem_req_ready;
  assign rsp_drop        = mem_rsp_valid && (discard != '0);
  assign push            = mem_rsp_valid && (discard == '0) && !redirect_valid;
  assign pop             = instr_valid && instr_ready && !redirect_valid;
  assign discard_next    = inflight - CW'(mem_rsp_valid);
  assign redirect_target = {redirect_pc[31:2], 2'b00};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      fetch_addr <= RESET_PC;
      head_pc    <= RESET_PC;
      count      <= '0;
      inflight   <= '0;
      discard    <= '0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      for (int i = 0; i < int'(DEPTH); i++) fifo_mem[i] <= '0;
    end else if (redirect_valid) begin
      // Everything still outstanding after this cycle's response belongs to the old stream.
      count      <= '0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fetch_addr <= redirect_target;
      head_pc    <= redirect_target;
      inflight   <= discard_next;
      discard    <= discard_next;
      state      <= (discard_next == '0) ? RUN : DRAIN;
    end else begin
      if (accept) fetch_addr <= fetch_addr + 32'd4;
      case ({accept, mem_rsp_valid})
        2'b10:   inflight <= inflight + 1'b1;
        2'b01:   inflight <= inflight - 1'b1;
        default: ;
      endcase
      if (rsp_drop) discard <= discard - 1'b1;
      if (push) begin
        fifo_mem[wr_ptr] <= mem_rsp_data;
        wr_ptr           <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr  <= rd_ptr + 1'b1;
        head_pc <= head_pc + 32'd4;
      end
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase
      case (state)
        IDLE:    state <= RUN;
        DRAIN:   if (rsp_drop && (discard == CW'(1))) state <= RUN;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_instr_prefetch.sv
// Bench for instr_prefetch: an in-order variable-latency memory plus a stream/epoch reference
// model of the fetched instruction sequence, checked every cycle and in per-scenario tasks.
module tb_instr_prefetch;
  localparam int          DEPTH    = 4;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam logic [1:0]  ST_IDLE  = 2'd0;
  localparam logic [1:0]  ST_RUN   = 2'd1;
  localparam logic [1:0]  ST_DRAIN = 2'd2;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        mem_req_valid;
  logic        mem_req_ready = 1'b0;
  logic [31:0] mem_req_addr;
  logic        mem_rsp_valid = 1'b0;
  logic [31:0] mem_rsp_data = '0;
  logic        instr_valid;
  logic        instr_ready = 1'b0;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic [1:0]  dbg_state;

  always #5 clk = ~clk;

  instr_prefetch #(.DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
    .clk(clk), .reset(reset),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_req_addr(mem_req_addr),
    .mem_rsp_valid(mem_rsp_valid), .mem_rsp_data(mem_rsp_data),
    .instr_valid(instr_valid), .instr_ready(instr_ready), .instr(instr), .instr_pc(instr_pc),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc), .dbg_state(dbg_state)
  );

  int errors = 0;
  int checks = 0;
  int cyc = 0;

  // memory environment
  logic [31:0] mem_addr_q[$];
  int          mem_due_q[$];
  int          last_due;
  int          lat_min, lat_max, ready_pct;

  // reference model: expected instruction stream and outstanding requests tagged with an epoch
  logic [31:0] exp_q[$];
  logic [31:0] out_addr_q[$];
  int          out_epoch_q[$];
  int          epoch;
  logic [31:0] m_fetch, m_head;
  bit          started;
  logic [31:0] acc_log[$];
  logic [31:0] pop_log[$];

  function automatic logic [31:0] word(input logic [31:0] a);
    return (a * 32'h0100_0193) ^ 32'h5A5A_1234;
  endfunction

  function automatic int stale_count();
    int n = 0;
    foreach (out_epoch_q[i]) if (out_epoch_q[i] != epoch) n++;
    return n;
  endfunction

  task automatic model_reset();
    exp_q.delete(); out_addr_q.delete(); out_epoch_q.delete();
    mem_addr_q.delete(); mem_due_q.delete();
    last_due = 0; epoch = 0; started = 0;
    m_fetch = RESET_PC; m_head = RESET_PC;
  endtask

  // One clock cycle, entered and left at a falling edge with inputs already chosen.
  task automatic step();
    logic        exp_rv;
    logic [1:0]  exp_st;
    logic        s_acc, s_rsp, s_pop;
    logic [31:0] s_addr, a;
    int          e, due;
    mem_req_ready = ($urandom_range(99, 0) < ready_pct);
    mem_rsp_valid = 1'b0;
    mem_rsp_data  = '0;
    if (reset) model_reset();
    #1;
    if (!reset) begin
      if (lat_max == 0) begin
        if (mem_req_valid && mem_req_ready) begin
          mem_rsp_valid = 1'b1;
          mem_rsp_data  = word(mem_req_addr);
        end
      end else if (mem_addr_q.size() > 0 && mem_due_q[0] <= cyc) begin
        mem_rsp_valid = 1'b1;
        mem_rsp_data  = word(mem_addr_q.pop_front());
        void'(mem_due_q.pop_front());
      end
    end
    #1;
    exp_rv = started && !reset && (stale_count() == 0) && !redirect_valid &&
             ((exp_q.size() + out_addr_q.size()) < DEPTH);
    exp_st = (reset || !started) ? ST_IDLE : (stale_count() > 0) ? ST_DRAIN : ST_RUN;
    checks++;
    if (mem_req_valid !== exp_rv) begin
      errors++; $display("FAIL req_valid cyc=%0d: got %b exp %b", cyc, mem_req_valid, exp_rv);
    end
    checks++;
    if (mem_req_addr !== m_fetch) begin
      errors++; $display("FAIL req_addr cyc=%0d: got %h exp %h", cyc, mem_req_addr, m_fetch);
    end
    checks++;
    if (instr_valid !== (exp_q.size() > 0)) begin
      errors++; $display("FAIL instr_valid cyc=%0d: got %b exp %b", cyc, instr_valid, exp_q.size() > 0);
    end
    checks++;
    if (instr_pc !== m_head) begin
      errors++; $display("FAIL instr_pc cyc=%0d: got %h exp %h", cyc, instr_pc, m_head);
    end
    if (exp_q.size() > 0) begin
      checks++;
      if (instr !== exp_q[0]) begin
        errors++; $display("FAIL instr cyc=%0d: got %h exp %h", cyc, instr, exp_q[0]);
      end
    end
    checks++;
    if (dbg_state !== exp_st) begin
      errors++; $display("FAIL state cyc=%0d: got %0d exp %0d", cyc, dbg_state, exp_st);
    end
    s_acc  = mem_req_valid && mem_req_ready;
    s_rsp  = mem_rsp_valid;
    s_pop  = instr_valid && instr_ready && !redirect_valid && (exp_q.size() > 0);
    s_addr = mem_req_addr;
    @(posedge clk);
    if (!reset) begin
      if (s_acc) begin
        out_addr_q.push_back(m_fetch);
        out_epoch_q.push_back(epoch);
        acc_log.push_back(s_addr);
        if (lat_max > 0) begin
          due = cyc + int'($urandom_range(lat_max, lat_min));
          if (due <= last_due) due = last_due + 1;
          last_due = due;
          mem_addr_q.push_back(s_addr);
          mem_due_q.push_back(due);
        end
        m_fetch = m_fetch + 32'd4;
      end
      if (s_pop) begin
        void'(exp_q.pop_front());
        pop_log.push_back(m_head);
        m_head = m_head + 32'd4;
      end
      if (s_rsp && out_addr_q.size() > 0) begin
        a = out_addr_q.pop_front();
        e = out_epoch_q.pop_front();
        if (e == epoch && !redirect_valid) begin
          checks++;
          if (exp_q.size() >= DEPTH) begin
            errors++; $display("FAIL push_full cyc=%0d: got size %0d exp below %0d", cyc, exp_q.size(), DEPTH);
          end
          exp_q.push_back(word(a));
        end
      end
      if (redirect_valid) begin
        exp_q.delete();
        epoch++;
        m_fetch = {redirect_pc[31:2], 2'b00};
        m_head  = {redirect_pc[31:2], 2'b00};
      end
      started = 1;
    end
    cyc++;
    @(negedge clk);
  endtask

  task automatic do_reset();
    reset = 1'b1; redirect_valid = 1'b0;
    step();
    reset = 1'b0;
    acc_log.delete(); pop_log.delete();
  endtask

  task automatic test_reset();
    reset = 1'b1; instr_ready = 1'b0; redirect_valid = 1'b0;
    ready_pct = 100; lat_min = 0; lat_max = 0;
    #2;
    checks++; if (mem_req_valid !== 1'b0) begin errors++; $display("FAIL rst_req_valid: got %b exp 0", mem_req_valid); end
    checks++; if (instr_valid !== 1'b0) begin errors++; $display("FAIL rst_instr_valid: got %b exp 0", instr_valid); end
    checks++; if (mem_req_addr !== RESET_PC) begin errors++; $display("FAIL rst_req_addr: got %h exp %h", mem_req_addr, RESET_PC); end
    checks++; if (instr_pc !== RESET_PC) begin errors++; $display("FAIL rst_instr_pc: got %h exp %h", instr_pc, RESET_PC); end
    checks++; if (instr !== 32'h0) begin errors++; $display("FAIL rst_instr: got %h exp 0", instr); end
    checks++; if (dbg_state !== ST_IDLE) begin errors++; $display("FAIL rst_state: got %0d exp %0d", dbg_state, ST_IDLE); end
    @(negedge clk);
    do_reset();
  endtask

  task automatic test_stream();
    lat_min = 0; lat_max = 0; ready_pct = 100; instr_ready = 1'b1;
    do_reset();
    repeat (20) step();
    checks++;
    if (pop_log.size() < 5) begin
      errors++; $display("FAIL stream_count: got %0d exp at least 5", pop_log.size());
    end else begin
      for (int i = 0; i < 5; i++) begin
        checks++;
        if (pop_log[i] !== RESET_PC + 32'(4 * i)) begin
          errors++; $display("FAIL stream_pc%0d: got %h exp %h", i, pop_log[i], RESET_PC + 32'(4 * i));
        end
      end
    end
  endtask

  task automatic test_backpressure();
    lat_min = 1; lat_max = 1; ready_pct = 100; instr_ready = 1'b0;
    do_reset();
    repeat (12) step();
    checks++;
    if (acc_log.size() != DEPTH) begin
      errors++; $display("FAIL bp_req_count: got %0d exp %0d", acc_log.size(), DEPTH);
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        checks++;
        if (acc_log[i] !== RESET_PC + 32'(4 * i)) begin
          errors++; $display("FAIL bp_addr%0d: got %h exp %h", i, acc_log[i], RESET_PC + 32'(4 * i));
        end
      end
    end
    instr_ready = 1'b1; step(); instr_ready = 1'b0;
    repeat (3) step();
    checks++;
    if (acc_log.size() != DEPTH + 1 || acc_log[acc_log.size() - 1] !== RESET_PC + 32'h10) begin
      errors++; $display("FAIL bp_release: got %0d reqs exp %0d ending at %h", acc_log.size(), DEPTH + 1, RESET_PC + 32'h10);
    end
  endtask

  task automatic test_redirect_drain();
    bit hit = 0;
    lat_min = 3; lat_max = 3; ready_pct = 100; instr_ready = 1'b1;
    do_reset();
    for (int i = 0; i < 20 && !hit; i++) begin
      if (out_addr_q.size() >= 2 && !(mem_due_q.size() > 0 && mem_due_q[0] <= cyc)) hit = 1;
      else step();
    end
    checks++;
    if (!hit) begin errors++; $display("FAIL drain_setup: got timeout exp 2 in flight"); end
    redirect_valid = 1'b1; redirect_pc = 32'h100;
    step();
    redirect_valid = 1'b0;
    pop_log.delete();
    checks++;
    if (dbg_state !== ST_DRAIN) begin errors++; $display("FAIL drain_state: got %0d exp %0d", dbg_state, ST_DRAIN); end
    repeat (12) step();
    checks++;
    if (pop_log.size() == 0 || pop_log[0] !== 32'h100) begin
      errors++; $display("FAIL drain_first_pc: got %0d pops exp first %h", pop_log.size(), 32'h100);
    end
  endtask

  task automatic test_redirect_rsp_pop();
    bit hit = 0;
    int exp_disc;
    lat_min = 2; lat_max = 2; ready_pct = 100; instr_ready = 1'b1;
    do_reset();
    for (int i = 0; i < 30 && !hit; i++) begin
      if (mem_due_q.size() > 0 && mem_due_q[0] <= cyc && exp_q.size() > 0 && out_addr_q.size() >= 2) hit = 1;
      else step();
    end
    checks++;
    if (!hit) begin errors++; $display("FAIL rsp_pop_setup: got timeout exp response with pop"); end
    exp_disc = out_addr_q.size() - 1;
    redirect_valid = 1'b1; redirect_pc = 32'h200;
    step();
    redirect_valid = 1'b0;
    checks++;
    if (instr_valid !== 1'b0) begin errors++; $display("FAIL rsp_pop_flush: got %b exp 0", instr_valid); end
    checks++;
    if (instr_pc !== 32'h200) begin errors++; $display("FAIL rsp_pop_head: got %h exp %h", instr_pc, 32'h200); end
    checks++;
    if (stale_count() != exp_disc) begin errors++; $display("FAIL rsp_pop_discard: got %0d exp %0d", stale_count(), exp_disc); end
    repeat (10) step();
  endtask

  task automatic test_align_wrap();
    lat_min = 1; lat_max = 1; ready_pct = 100; instr_ready = 1'b1;
    do_reset();
    step();
    redirect_valid = 1'b1; redirect_pc = 32'h102;
    step();
    redirect_valid = 1'b0;
    checks++;
    if (mem_req_addr !== 32'h100) begin errors++; $display("FAIL align_addr: got %h exp %h", mem_req_addr, 32'h100); end
    repeat (4) step();
    redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFF8;
    step();
    redirect_valid = 1'b0;
    acc_log.delete();
    repeat (8) step();
    checks++;
    if (acc_log.size() < 3 || acc_log[0] !== 32'hFFFF_FFF8 || acc_log[1] !== 32'hFFFF_FFFC || acc_log[2] !== 32'h0) begin
      errors++; $display("FAIL wrap_seq: got %0d reqs first %h exp fff8,fffc,0", acc_log.size(),
                         acc_log.size() > 0 ? acc_log[0] : 32'h0);
    end
  endtask

  task automatic test_random();
    lat_min = 1; lat_max = 4; ready_pct = 70;
    do_reset();
    repeat (1500) begin
      instr_ready    = ($urandom_range(99, 0) < 65);
      redirect_valid = ($urandom_range(99, 0) < 3);
      redirect_pc    = $urandom;
      step();
    end
    redirect_valid = 1'b0;
  endtask

  task automatic test_reset_mid();
    lat_min = 3; lat_max = 3; ready_pct = 100; instr_ready = 1'b0;
    do_reset();
    repeat (6) step();
    reset = 1'b1;
    #2;
    checks++;
    if (instr_valid !== 1'b0 || mem_req_valid !== 1'b0) begin
      errors++; $display("FAIL mid_reset: got valid %b req %b exp 0 0", instr_valid, mem_req_valid);
    end
    @(negedge clk);
    step();
    reset = 1'b0;
    acc_log.delete();
    step();
    checks++;
    if (acc_log.size() != 0) begin errors++; $display("FAIL mid_idle: got %0d reqs exp 0", acc_log.size()); end
    step();
    checks++;
    if (acc_log.size() != 1 || acc_log[0] !== RESET_PC) begin
      errors++; $display("FAIL mid_first_req: got %0d reqs exp 1 at %h", acc_log.size(), RESET_PC);
    end
    instr_ready = 1'b1;
    repeat (10) step();
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_stream();
    test_backpressure();
    test_redirect_drain();
    test_redirect_rsp_pop();
    test_align_wrap();
    test_random();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
